// File: rtl/display_compositor.sv
// Display compositor: layered sprite pixel path with a frame-synchronous
// screen-state machine (START / PLAY / LOSE / WIN).
module display_compositor #(
  parameter int          N_LAYERS     = 6,
  parameter int          HEALTH_W     = 3,
  parameter int          BORDER_X     = 960,
  parameter int          BORDER_Y     = 640,
  parameter logic [31:0] START_CODE_A = 32'h20DF_5BA4,
  parameter logic [31:0] START_CODE_B = 32'h20DF_5AA5,
  parameter logic [31:0] RESTART_CODE = 32'h20DF_10EF
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   nf_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic [31:0]            ir_in,
  input  logic                   ir_valid_in,
  input  logic [HEALTH_W-1:0]    player_health_in,
  input  logic [HEALTH_W-1:0]    opponent_health_in,
  input  logic [24*N_LAYERS-1:0] layer_pixel_in,
  input  logic [N_LAYERS-1:0]    layer_en_in,
  input  logic [23:0]            start_pixel_in,
  input  logic [23:0]            win_pixel_in,
  input  logic [23:0]            lose_pixel_in,
  output logic [23:0]            pixel_out,
  output logic [10:0]            hcount_out,
  output logic [9:0]             vcount_out,
  output logic [1:0]             state_out
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_PLAY  = 2'd1,
    S_LOSE  = 2'd2,
    S_WIN   = 2'd3
  } state_t;

  typedef struct packed {
    logic [23:0] layer;
    logic        border;
    logic [23:0] start_px;
    logic [23:0] win_px;
    logic [23:0] lose_px;
    logic [10:0] h;
    logic [9:0]  v;
  } s1_t;

  localparam logic [10:0] BX = 11'(BORDER_X);
  localparam logic [9:0]  BY = 10'(BORDER_Y);

  state_t      state_q;
  logic        pend_q;
  state_t      tgt_q;
  logic        ir_req;
  state_t      ir_tgt;
  logic        hp_req;
  state_t      hp_tgt;
  logic [23:0] layer_pick;
  logic        border;
  s1_t         s1_q;

  assign state_out = state_q;

  // Descending scan so the lowest-index opaque layer wins.
  always_comb begin
    layer_pick = '0;
    for (int k = N_LAYERS - 1; k >= 0; k--) begin
      if (layer_en_in[k] && (layer_pixel_in[24*k +: 24] != 24'h0))
        layer_pick = layer_pixel_in[24*k +: 24];
    end
  end

  assign border = ((hcount_in == BX) && (vcount_in <= BY)) ||
                  ((vcount_in == BY) && (hcount_in <= BX));

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      s1_q <= '0;
    end else begin
      s1_q.layer    <= layer_pick;
      s1_q.border   <= border;
      s1_q.start_px <= start_pixel_in;
      s1_q.win_px   <= win_pixel_in;
      s1_q.lose_px  <= lose_pixel_in;
      s1_q.h        <= hcount_in;
      s1_q.v        <= vcount_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pixel_out  <= '0;
      hcount_out <= '0;
      vcount_out <= '0;
    end else begin
      hcount_out <= s1_q.h;
      vcount_out <= s1_q.v;
      unique case (state_q)
        S_START: pixel_out <= s1_q.start_px;
        S_PLAY:  pixel_out <= s1_q.border ? 24'hFFFFFF : s1_q.layer;
        S_LOSE:  pixel_out <= s1_q.lose_px;
        S_WIN:   pixel_out <= s1_q.win_px;
      endcase
    end
  end

  always_comb begin
    ir_req = 1'b0;
    ir_tgt = S_START;
    unique case (1'b1)
      (ir_valid_in && (state_q == S_START) &&
       ((ir_in == START_CODE_A) || (ir_in == START_CODE_B))): begin
        ir_req = 1'b1;
        ir_tgt = S_PLAY;
      end
      (ir_valid_in && ((state_q == S_LOSE) || (state_q == S_WIN)) &&
       (ir_in == RESTART_CODE)): begin
        ir_req = 1'b1;
        ir_tgt = S_START;
      end
      default: ;
    endcase
  end

  always_comb begin
    hp_req = nf_in && (state_q == S_PLAY) &&
             ((player_health_in == '0) || (opponent_health_in == '0));
    hp_tgt = (player_health_in == '0) ? S_LOSE : S_WIN;
  end

  // Requests only park in pend/tgt; state moves on the frame boundary.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_START;
      pend_q  <= 1'b0;
      tgt_q   <= S_START;
    end else if (nf_in) begin
      pend_q <= 1'b0;
      if (ir_req)
        state_q <= ir_tgt;
      else if (hp_req)
        state_q <= hp_tgt;
      else if (pend_q)
        state_q <= tgt_q;
    end else if (ir_req) begin
      pend_q <= 1'b1;
      tgt_q  <= ir_tgt;
    end
  end

endmodule
